// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
//   Sequential instruction encoder that feeds the single-cycle MIPS instruction
//   memory. Symbolic instruction fields arrive over a valid/ready handshake.
//   Each one is packed into a 32-bit word and written to the next imem address.
//
//   Flow: IDLE -(transfer)-> ENC -> WR -> IDLE.
//         WR goes to FULL once DEPTH words have been written.
//         An illegal op sets the sticky error flag, skips WR and returns to IDLE.
//
// Parameters
//   ADDR_W   imem word-address width
//   DEPTH    words writable before full (1 <= DEPTH <= 2**ADDR_W)
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   clear            synchronous soft clear of pointer, error and full
//   in_valid         instruction fields valid (handshake input)
//   in_ready         encoder can accept fields (handshake output)
//   op_sel           0 LW,1 SW,2 ADD,3 SUB,4 SLT,5 MUL,6 ADDI,7 BEQ,8 J,
//                    9-15 illegal
//   rs, rt, rd       register fields
//   imm              I-type immediate / branch offset
//   target           J-type word target
//   wr_en            imem write strobe, one cycle per word
//   wr_addr          imem word address
//   wr_data          encoded word; only meaningful while wr_en is high
//   count            words written since reset/clear
//   full             DEPTH words written; no further accepts
//   error            sticky flag: an illegal op_sel was accepted
// -----------------------------------------------------------------------------
module mips_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENC,
    S_WR,
    S_FULL
  } state_t;

  // Symbolic operation codes carried on op_sel.
  localparam logic [3:0] OP_LW   = 4'd0;
  localparam logic [3:0] OP_SW   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  state_t      state;
  logic        wr_en_q;
  logic [ADDR_W:0] count_nxt;

  // Fields captured on transfer.
  logic [3:0]  op_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [15:0] imm_q;
  logic [25:0] tgt_q;

  logic        enc_legal;
  logic [31:0] enc_word;
  logic        transfer;

  // Reset and clear both gate in_ready. An edge with clear high can
  // therefore never also be a transfer edge.
  assign in_ready  = (state == S_IDLE) && rst_n && !clear;
  assign transfer  = in_valid && in_ready;

  // Clear aborts a pending write in the same cycle it is asserted.
  assign wr_en     = wr_en_q && !clear;
  assign wr_addr   = count[ADDR_W-1:0];
  assign count_nxt = count + ONE_C;

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    unique case (op_q)
      OP_LW:   enc_word = {6'b100011, rs_q, rt_q, imm_q};
      OP_SW:   enc_word = {6'b101011, rs_q, rt_q, imm_q};
      OP_ADDI: enc_word = {6'b001000, rs_q, rt_q, imm_q};
      OP_BEQ:  enc_word = {6'b000100, rs_q, rt_q, imm_q};
      OP_ADD:  enc_word = {6'h00, rs_q, rt_q, rd_q, 5'b0, 6'b100000};
      OP_SUB:  enc_word = {6'h00, rs_q, rt_q, rd_q, 5'b0, 6'b100010};
      OP_SLT:  enc_word = {6'h00, rs_q, rt_q, rd_q, 5'b0, 6'b101010};
      OP_MUL:  enc_word = {6'h00, rs_q, rt_q, rd_q, 5'b0, 6'b011100};
      OP_J:    enc_word = {6'b000010, tgt_q};
      default: enc_legal = 1'b0;
    endcase
  end

  // NOTE: these capture registers are datapath only. Their contents are never
  // observed before a transfer loads them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (transfer) begin
      op_q  <= op_sel;
      rs_q  <= rs;
      rt_q  <= rt;
      rd_q  <= rd;
      imm_q <= imm;
      tgt_q <= target;
    end
  end

  // NOTE: state registers use non-blocking assignments only. Every register
  // then updates from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wr_en_q <= 1'b0;
      wr_data <= '0;
      count   <= '0;
      full    <= 1'b0;
      error   <= 1'b0;
    end else if (clear) begin
      // wr_data is kept; it only has meaning while wr_en is high.
      state   <= S_IDLE;
      wr_en_q <= 1'b0;
      count   <= '0;
      full    <= 1'b0;
      error   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (transfer) state <= S_ENC;
        end
        S_ENC: begin
          if (enc_legal) begin
            wr_data <= enc_word;
            wr_en_q <= 1'b1;
            state   <= S_WR;
          end else begin
            // Illegal op: flag it and drop the instruction without a write.
            error <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_WR: begin
          wr_en_q <= 1'b0;
          count   <= count_nxt;
          if (count_nxt == DEPTH_C) begin
            full  <= 1'b1;
            state <= S_FULL;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FULL: begin
          // Only clear or reset leave FULL; the pointer never wraps.
          state <= S_FULL;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_mips_instr_encoder
//   Bench for mips_instr_encoder. It uses two instances. dut_a has the default
//   DEPTH of 256. dut_b has DEPTH=4 with a 2-bit address and covers the FULL
//   behaviour. Field inputs, clk and rst_n are shared. in_valid and clear are
//   routed to the instance picked by sel, and that instance's outputs are
//   observed. Expected words come from a table-driven arithmetic model of the
//   MIPS field layout.
// -----------------------------------------------------------------------------
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        v;
  logic        clr;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic        a_rdy, a_wen, a_full, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_data;
  logic [8:0]  a_cnt;
  logic        b_rdy, b_wen, b_full, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_cnt;

  logic        rdy_o, wen_o, full_o, err_o;
  logic [7:0]  addr_o;
  logic [31:0] data_o;
  logic [8:0]  cnt_o;

  int tests = 0;
  int fails = 0;
  int unsigned exp_count;
  logic        exp_err;
  logic [39:0] wq[$];

  always #5 clk = ~clk;

  mips_instr_encoder dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clr && !sel), .in_valid(v && !sel),
    .in_ready(a_rdy), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target), .wr_en(a_wen), .wr_addr(a_addr),
    .wr_data(a_data), .count(a_cnt), .full(a_full), .error(a_err)
  );

  mips_instr_encoder #(.ADDR_W(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clr && sel), .in_valid(v && sel),
    .in_ready(b_rdy), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target), .wr_en(b_wen), .wr_addr(b_addr),
    .wr_data(b_data), .count(b_cnt), .full(b_full), .error(b_err)
  );

  assign rdy_o  = sel ? b_rdy  : a_rdy;
  assign wen_o  = sel ? b_wen  : a_wen;
  assign full_o = sel ? b_full : a_full;
  assign err_o  = sel ? b_err  : a_err;
  assign data_o = sel ? b_data : a_data;
  assign addr_o = sel ? {6'b0, b_addr} : a_addr;
  assign cnt_o  = sel ? {6'b0, b_cnt}  : a_cnt;

  // Records every write of the observed instance as {addr, data}.
  always @(negedge clk) if (wen_o) wq.push_back({addr_o, data_o});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MIPS encoding built from field positions: op<<26, rs<<21, rt<<16, rd<<11.
  function automatic logic [31:0] model_word(input int op, input int r_s, input int r_t,
                                             input int r_d, input int im, input int tg);
    longint unsigned opc[9]   = '{35, 43, 0, 0, 0, 0, 8, 4, 2};
    longint unsigned funct[9] = '{0, 0, 32, 34, 42, 28, 0, 0, 0};
    longint unsigned w;
    if (op >= 2 && op <= 5)
      w = r_s * 64'd2097152 + r_t * 64'd65536 + r_d * 64'd2048 + funct[op];
    else if (op == 8)
      w = opc[op] * 64'd67108864 + tg;
    else
      w = opc[op] * 64'd67108864 + r_s * 64'd2097152 + r_t * 64'd65536 + im;
    return w[31:0];
  endfunction

  task automatic drive(input int op, input int r_s, input int r_t, input int r_d,
                       input int im, input int tg);
    op_sel = 4'(op); rs = 5'(r_s); rt = 5'(r_t); rd = 5'(r_d);
    imm = 16'(im); target = 26'(tg);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    #1 check("ready_low_in_clear", rdy_o, 1'b0);
    @(posedge clk); #1 clr = 1'b0;
    exp_count = 0; exp_err = 1'b0;
  endtask

  // One instruction through the observed instance, with cycle-exact checks.
  task automatic send(input int op, input int r_s, input int r_t, input int r_d,
                      input int im, input int tg);
    int waited = 0;
    logic legal = (op <= 8);
    @(negedge clk);
    while (!rdy_o && waited < 20) begin @(negedge clk); waited++; end
    check("ready_before_send", rdy_o, 1'b1);
    drive(op, r_s, r_t, r_d, im, tg);
    v = 1'b1;
    @(posedge clk); #1 v = 1'b0;                    // transfer edge N
    @(negedge clk);                                 // cycle N+1
    check("wr_en_idle_enc", wen_o, 1'b0);
    check("ready_low_enc", rdy_o, 1'b0);
    @(negedge clk);                                 // cycle N+2
    if (legal) begin
      check("wr_en_n2", wen_o, 1'b1);
      check("wr_addr", addr_o, 8'(exp_count));
      check("wr_data", data_o, model_word(op, r_s, r_t, r_d, im, tg));
      exp_count++;
    end else begin
      check("no_wr_illegal", wen_o, 1'b0);
      exp_err = 1'b1;
      check("error_set", err_o, 1'b1);
    end
    @(negedge clk);                                 // cycle N+3
    check("wr_en_one_cycle", wen_o, 1'b0);
    check("count", cnt_o, 9'(exp_count));
    check("error", err_o, exp_err);
    check("ready_after", rdy_o, 1'b1);
  endtask

  initial begin
    int waited;
    logic [31:0] exp_w[5];
    sel = 1'b0; v = 1'b0; clr = 1'b0; rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    exp_count = 0; exp_err = 1'b0;

    // Reset values, in_ready low while rst_n is low.
    repeat (3) @(negedge clk);
    check("rst_ready", rdy_o, 1'b0);
    check("rst_wr_en", wen_o, 1'b0);
    check("rst_addr", addr_o, 8'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_count", cnt_o, 9'd0);
    check("rst_full", full_o, 1'b0);
    check("rst_error", err_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", rdy_o, 1'b1);

    // Single ADD.
    send(2, 1, 2, 3, 0, 0);
    check("add_word_const", model_word(2, 1, 2, 3, 0, 0), 32'h00221820);

    // Directed stream from address 0.
    do_clear();
    wq.delete();
    send(0, 1, 2, 0, 4, 0);
    send(3, 4, 3, 5, 0, 0);
    send(5, 1, 1, 6, 0, 0);
    send(7, 1, 2, 0, 16'hFFFF, 0);
    send(8, 0, 0, 0, 0, 26'h10);
    exp_w = '{32'h8C220004, 32'h00832822, 32'h0021301C, 32'h1022FFFF, 32'h08000010};
    check("stream_len", wq.size(), 5);
    for (int i = 0; i < 5 && i < wq.size(); i++)
      check($sformatf("stream_%0d", i), wq[i], {8'(i), exp_w[i]});

    // Illegal op, then a legal op at the same address.
    send(15, 7, 7, 7, 7, 7);
    send(2, 1, 2, 3, 0, 0);

    // Clear during ENC aborts the write and clears error.
    check("error_before_clear", err_o, 1'b1);
    @(negedge clk);
    drive(2, 9, 9, 9, 0, 0); v = 1'b1;
    @(posedge clk); #1 v = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    exp_count = 0; exp_err = 1'b0;
    wq.delete();
    repeat (3) @(negedge clk);
    check("clr_enc_no_write", wq.size(), 0);
    check("clr_enc_count", cnt_o, 9'd0);
    check("clr_enc_error", err_o, 1'b0);
    send(3, 2, 2, 2, 0, 0);

    // Reset during the WR cycle.
    @(negedge clk);
    drive(6, 3, 4, 0, 16'h1234, 0); v = 1'b1;
    @(posedge clk); #1 v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wr_before_rst", wen_o, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    wq.delete();
    check("rst_wr_wen", wen_o, 1'b0);
    check("rst_wr_count", cnt_o, 9'd0);
    check("rst_wr_data", data_o, 32'd0);
    check("rst_wr_ready", rdy_o, 1'b0);
    rst_n = 1'b1;
    exp_count = 0; exp_err = 1'b0;
    @(negedge clk);
    check("rst_wr_nowrite", wq.size(), 0);
    send(8, 0, 0, 0, 0, 26'h3FFFFFF);

    // in_valid high with clear in the same cycle: accepted one cycle later.
    @(negedge clk);
    drive(4, 5, 6, 7, 0, 0); v = 1'b1; clr = 1'b1;
    #1 check("clr_valid_ready", rdy_o, 1'b0);
    @(posedge clk); #1 clr = 1'b0;
    exp_count = 0;
    @(negedge clk);
    check("clr_no_transfer", rdy_o, 1'b1);
    @(posedge clk); #1 v = 1'b0;
    @(negedge clk);
    check("clr_valid_n1", wen_o, 1'b0);
    @(negedge clk);
    check("clr_valid_wen", wen_o, 1'b1);
    check("clr_valid_addr", addr_o, 8'd0);
    check("clr_valid_data", data_o, model_word(4, 5, 6, 7, 0, 0));
    exp_count = 1;

    // Randomized traffic, occasional illegal ops.
    for (int i = 0; i < 30; i++) begin
      int op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 65535), $urandom_range(0, 67108863));
    end

    // DEPTH=4 instance: five back-to-back ops, four written, then full.
    sel = 1'b1;
    do_clear();
    wq.delete();
    v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int op = $urandom_range(0, 8);
      int f_rs = $urandom_range(0, 31), f_rt = $urandom_range(0, 31), f_rd = $urandom_range(0, 31);
      int f_im = $urandom_range(0, 65535), f_tg = $urandom_range(0, 67108863);
      @(negedge clk);
      drive(op, f_rs, f_rt, f_rd, f_im, f_tg);
      exp_w[i] = model_word(op, f_rs, f_rt, f_rd, f_im, f_tg);
      waited = 0;
      while (!rdy_o && waited < 8) begin @(negedge clk); waited++; end
      if (i < 4) begin
        check("d4_ready", rdy_o, 1'b1);
        @(posedge clk);
      end
    end
    check("d4_full", full_o, 1'b1);
    check("d4_ready_full", rdy_o, 1'b0);
    check("d4_count", cnt_o, 9'd4);
    check("d4_writes", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++)
      check($sformatf("d4_word_%0d", i), wq[i], {8'(i), exp_w[i]});
    // Clear with the fifth op still pending; it lands at address 0.
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    check("d4_full_cleared", full_o, 1'b0);
    check("d4_ready_clear", rdy_o, 1'b1);
    @(posedge clk); #1 v = 1'b0;
    repeat (3) @(negedge clk);
    check("d4_fifth_written", wq.size(), 5);
    if (wq.size() == 5) check("d4_fifth_word", wq[4], {8'd0, exp_w[4]});
    check("d4_count_after", cnt_o, 9'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
